// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: processor-wide fetch constants, halt opcode, and IF/ID register type
package fetch_stage_pkg;
  localparam int PC_W = 32;
  localparam int INSTR_W = 28;
  localparam int OPC_HI = 27;
  localparam int OPC_LO = 24;
  localparam logic [3:0] HALT_OPCODE = 4'b1111;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0] pc_plus4;
    logic valid;
  } ifid_t;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: program counter plus IF/ID pipeline register feeding decode.
// Ports: clk, reset (async active-low); PC -> instruction memory, Instr <- memory (combinational);
// stall/flush/branch_taken/branch_target from hazard and branch logic;
// instr_d/pc_plus4_d/valid_d form the IF/ID register; halted reports a frozen fetch.
// Build option: FETCH_HALT_EN enables the halt-opcode freeze; otherwise halted is tied to 0.
module fetch_stage #(
  parameter int PC_W = fetch_stage_pkg::PC_W,
  parameter int INSTR_W = fetch_stage_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    PC,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [INSTR_W-1:0] instr_d,
  output logic [PC_W-1:0]    pc_plus4_d,
  output logic               valid_d,
  output logic               halted
);
  import fetch_stage_pkg::*;
  logic [PC_W-1:0] pc_q, pc_d, pc_plus4;
  ifid_t ifid_q, ifid_d;
  logic halted_q, halted_d, is_halt, capture;
  assign pc_plus4 = pc_q + PC_W'(4);
`ifdef FETCH_HALT_EN
  assign is_halt = Instr[OPC_HI:OPC_LO] == HALT_OPCODE;
`else
  assign is_halt = 1'b0;
`endif
  // a halt only counts when it is actually captured into IF/ID, never on a squashed or held slot
  always_comb begin
    capture = !(flush || branch_taken || stall);
    pc_d = branch_taken ? {branch_target[PC_W-1:2], 2'b00} : (halted_q || stall) ? pc_q : pc_plus4;
    ifid_d = (flush || branch_taken) ? '0 : stall ? ifid_q : '{instr: Instr, pc_plus4: pc_plus4, valid: !halted_q};
    halted_d = halted_q || (capture && is_halt);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      ifid_q <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ifid_q <= ifid_d;
      halted_q <= halted_d;
    end
  end
  assign PC = pc_q;
  assign instr_d = ifid_q.instr;
  assign pc_plus4_d = ifid_q.pc_plus4;
  assign valid_d = ifid_q.valid;
  assign halted = halted_q;
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the vector processor: holds the program counter, drives the PC into the combinational instruction memory, and captures the returned 28-bit instruction into the IF/ID pipeline register for decode. It sits directly upstream of the instruction memory and directly downstream of the branch/hazard logic, which supply redirect, stall and flush requests.

## Interface
- PC_W, 32, program-counter width
- INSTR_W, 28, instruction width returned by instruction memory
- RESET_PC, 32'h0, PC value loaded on reset (low 2 bits must be 0)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- PC  out  PC_W  current fetch address to instruction memory
- Instr  in  INSTR_W  instruction read combinationally at PC
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  invalidate IF/ID contents
- branch_taken  in  1  redirect fetch to branch_target
- branch_target  in  PC_W  redirect address
- instr_d  out  INSTR_W  IF/ID instruction
- pc_plus4_d  out  PC_W  IF/ID copy of fetch PC + 4
- valid_d  out  1  IF/ID slot holds a real instruction
- halted  out  1  fetch frozen by halt instruction

## Operation
- Reset (reset=0, asynchronous): PC=RESET_PC, instr_d=0, pc_plus4_d=0, valid_d=0, halted=0.
- PC next-value priority: branch_taken > halted > stall > normal.
  - branch_taken: PC <= {branch_target[PC_W-1:2], 2'b00} (misaligned targets forced word-aligned).
  - halted or stall: PC holds.
  - normal: PC <= PC + 4, modulo 2^PC_W (0xFFFFFFFC wraps to 0x0).
- IF/ID priority: flush or branch_taken > stall > normal.
  - flush/branch_taken: instr_d <= 0, pc_plus4_d <= 0, valid_d <= 0 (wrong-path instruction squashed).
  - stall: all IF/ID fields hold.
  - normal: instr_d <= Instr, pc_plus4_d <= PC + 4, valid_d <= 1 (0 if halted).
- stall and flush together: flush wins for IF/ID, PC still holds.
- branch_taken and stall together: redirect taken, IF/ID cleared.
- Memory addresses words with PC[27:2]; PC bits above 27 are carried but alias in memory; no range check.

## Timing
- PC is a register; Instr is valid combinationally within the same cycle.
- Fetch latency: instruction at PC appears on instr_d one clock after PC presents it.
- After reset release: first edge captures RAM[RESET_PC>>2] with valid_d=1, PC becomes RESET_PC+4.
- Branch penalty: one bubble (valid_d=0) on the cycle after branch_taken; target instruction on instr_d the cycle after that.
- Reset asserted mid-operation clears all state immediately, without waiting for clk.

## Configuration
- FETCH_HALT_EN defined: when normal IF/ID capture sees Instr[27:24] == HALT_OPCODE, halted <= 1 on that edge, the halt instruction is latched with valid_d=1, then PC freezes and later captures give valid_d=0; only reset clears halted (branch_taken still redirects PC but halted remains set and PC freezes after).
- FETCH_HALT_EN undefined: halted tied to 0; HALT_OPCODE treated as an ordinary instruction.

## Structure
- Shared package (processor-wide): PC_W/INSTR_W constants, HALT_OPCODE = 4'b1111, opcode field position [27:24], IF/ID struct type (instr, pc_plus4, valid).
- No sub-module; PC register and IF/ID register live in one module. Next-PC mux is inline logic.

## Test plan
- Reset then 4 free-running cycles, memory words 0..3 = A,B,C,D -> PC 0,4,8,12,16; instr_d A,B,C,D with valid_d=1 from cycle 1.
- stall high 2 cycles while PC=8 -> PC stays 8, instr_d stays B, valid_d stays 1; resumes with C.
- branch_taken with target 0x41 while PC=12 -> next PC=0x40, valid_d=0 for one cycle, then instr_d=RAM[16].
- stall+flush same cycle at PC=8 -> PC holds 8, valid_d=0, instr_d=0.
- PC preset 0xFFFFFFFC via branch -> next PC=0x0, no X.
- With FETCH_HALT_EN, halt opcode word at address 8 -> halted=1 after its capture, PC frozen at 12, valid_d=0 thereafter; async reset drop clears halted and PC to 0 before next edge.
